// File: rtl/bsg_cache_dma_responder.sv
// Flop-array memory that answers bsg_cache DMA bursts: reads stream stored words to the
// cache, writes store masked words from the cache. One burst at a time, one word per cycle.
module bsg_cache_dma_responder #(
   parameter int unsigned addr_width_p          = 30,
   parameter int unsigned data_width_p          = 64,
   parameter int unsigned block_size_in_words_p = 8,
   parameter int unsigned els_p                 = 1024,
   localparam int unsigned dma_pkt_width_lp     = 1 + block_size_in_words_p + addr_width_p
) (
   input  logic                        clk_i,
   input  logic                        reset_i,

   input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
   input  logic                        dma_pkt_v_i,
   output logic                        dma_pkt_yumi_o,

   output logic [data_width_p-1:0]     dma_data_o,
   output logic                        dma_data_v_o,
   input  logic                        dma_data_ready_i,

   input  logic [data_width_p-1:0]     dma_data_i,
   input  logic                        dma_data_v_i,
   output logic                        dma_data_yumi_o
);

   localparam int unsigned lg_bytes_lp  = $clog2(data_width_p / 8);
   localparam int unsigned lg_block_lp  = $clog2(block_size_in_words_p);
   localparam int unsigned lg_els_lp    = $clog2(els_p);
   localparam int unsigned blk_width_lp = lg_els_lp - lg_block_lp;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_e;

   state_e                           state_r, state_n;
   logic [lg_block_lp-1:0]           count_r, count_n;
   logic [blk_width_lp-1:0]          blk_r;
   logic [block_size_in_words_p-1:0] mask_r;
   logic                             write_not_read_r;
   logic                             latch_pkt;
   logic                             mem_we;
   logic [data_width_p-1:0]          mem_r [els_p];

   // Packet fields: write_not_read is the MSB, then mask, then byte address.
   logic                             pkt_write_not_read;
   logic [block_size_in_words_p-1:0] pkt_mask;
   logic [addr_width_p-1:0]          pkt_addr;
   logic [lg_els_lp-1:0]             pkt_word;
   logic [blk_width_lp-1:0]          pkt_blk;

   assign {pkt_write_not_read, pkt_mask, pkt_addr} = dma_pkt_i;

   // Word index wraps modulo the storage; dropping the in-block bits aligns to the burst base.
   assign pkt_word = lg_els_lp'(pkt_addr >> lg_bytes_lp);
   assign pkt_blk  = blk_width_lp'(pkt_word >> lg_block_lp);

   logic [lg_els_lp-1:0] mem_idx;
   assign mem_idx = {blk_r, count_r};

   logic count_last;
   assign count_last = (count_r == lg_block_lp'(block_size_in_words_p - 1));

   always_comb begin
      state_n         = state_r;
      count_n         = count_r;
      latch_pkt       = 1'b0;
      mem_we          = 1'b0;
      dma_pkt_yumi_o  = 1'b0;
      dma_data_v_o    = 1'b0;
      dma_data_o      = '0;
      dma_data_yumi_o = 1'b0;

      unique case (state_r)
         IDLE: begin
            dma_pkt_yumi_o = dma_pkt_v_i;
            if (dma_pkt_v_i) begin
               latch_pkt = 1'b1;
               count_n   = '0;
               state_n   = pkt_write_not_read ? WRITE : READ;
            end
         end

         READ: begin
            dma_data_v_o = 1'b1;
            dma_data_o   = mem_r[mem_idx];
            if (dma_data_ready_i) begin
               count_n = count_r + lg_block_lp'(1);
               if (count_last) begin
                  state_n = IDLE;
               end
            end
         end

         WRITE: begin
            dma_data_yumi_o = dma_data_v_i;
            if (dma_data_v_i) begin
               // Masked-off words are still consumed and counted, just not stored.
               mem_we  = write_not_read_r & mask_r[count_r];
               count_n = count_r + lg_block_lp'(1);
               if (count_last) begin
                  state_n = IDLE;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r          <= IDLE;
         count_r          <= '0;
         blk_r            <= '0;
         mask_r           <= '0;
         write_not_read_r <= 1'b0;
      end else begin
         state_r <= state_n;
         count_r <= count_n;
         if (latch_pkt) begin
            blk_r            <= pkt_blk;
            mask_r           <= pkt_mask;
            write_not_read_r <= pkt_write_not_read;
         end
      end
   end

   // Storage clears on reset; a burst cut short by reset is not rolled back.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_r <= '{default: '0};
      end else if (mem_we) begin
         mem_r[mem_idx] <= dma_data_i;
      end
   end

endmodule

// File: tb/tb_bsg_cache_dma_responder.sv
// Randomized self-checking bench for bsg_cache_dma_responder against a flat-array memory model.
module tb_bsg_cache_dma_responder;

   localparam int unsigned AW    = 30;
   localparam int unsigned DW    = 64;
   localparam int unsigned BW    = 8;
   localparam int unsigned ELS   = 1024;
   localparam int unsigned PKT_W = 1 + BW + AW;

   logic             clk_i;
   logic             reset_i;
   logic [PKT_W-1:0] dma_pkt_i;
   logic             dma_pkt_v_i;
   logic             dma_pkt_yumi_o;
   logic [DW-1:0]    dma_data_o;
   logic             dma_data_v_o;
   logic             dma_data_ready_i;
   logic [DW-1:0]    dma_data_i;
   logic             dma_data_v_i;
   logic             dma_data_yumi_o;

   bsg_cache_dma_responder #(
      .addr_width_p         (AW),
      .data_width_p         (DW),
      .block_size_in_words_p(BW),
      .els_p                (ELS)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .dma_pkt_i       (dma_pkt_i),
      .dma_pkt_v_i     (dma_pkt_v_i),
      .dma_pkt_yumi_o  (dma_pkt_yumi_o),
      .dma_data_o      (dma_data_o),
      .dma_data_v_o    (dma_data_v_o),
      .dma_data_ready_i(dma_data_ready_i),
      .dma_data_i      (dma_data_i),
      .dma_data_v_i    (dma_data_v_i),
      .dma_data_yumi_o (dma_data_yumi_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int          checks;
   int          errors;
   logic [DW-1:0] ref_mem [ELS];
   logic [DW-1:0] burst   [BW];
   bit          hold_v;
   bit          gaps;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Word index of the burst base: byte address to word, modulo storage, aligned to a block.
   function automatic int unsigned base_of(input logic [AW-1:0] a);
      return ((32'(a) >> 3) % ELS) & ~(BW - 1);
   endfunction

   task automatic accept(input bit wnr, input logic [BW-1:0] mask, input logic [AW-1:0] addr);
      dma_pkt_i        = {wnr, mask, addr};
      dma_pkt_v_i      = 1'b1;
      dma_data_v_i     = 1'($urandom);
      dma_data_ready_i = 1'($urandom);
      #1;
      check("pkt_yumi_idle", 64'(dma_pkt_yumi_o), 64'(1));
      check("idle_data_v", 64'(dma_data_v_o), 64'(0));
      check("idle_data_o", dma_data_o, 64'(0));
      check("idle_data_yumi", 64'(dma_data_yumi_o), 64'(0));
      tick();
      dma_pkt_v_i = hold_v;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [BW-1:0] mask);
      int unsigned base;
      base = base_of(addr);
      accept(1'b1, mask, addr);
      for (int k = 0; k < int'(BW); k++) begin
         while (gaps && $urandom_range(3) == 0) begin
            dma_data_v_i     = 1'b0;
            dma_data_ready_i = 1'($urandom);
            #1;
            check("wr_gap_yumi", 64'(dma_data_yumi_o), 64'(0));
            check("wr_gap_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(0));
            tick();
         end
         dma_data_v_i     = 1'b1;
         dma_data_i       = burst[k];
         dma_data_ready_i = 1'($urandom);
         #1;
         check("wr_yumi", 64'(dma_data_yumi_o), 64'(1));
         check("wr_data_v", 64'(dma_data_v_o), 64'(0));
         check("wr_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(0));
         tick();
         if (mask[k]) ref_mem[base + 32'(k)] = burst[k];
      end
      dma_data_v_i = 1'b0;
   endtask

   // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random ready
   task automatic do_read(input logic [AW-1:0] addr, input int mode);
      int unsigned base;
      int          k;
      int          cyc;
      base = base_of(addr);
      accept(1'b0, BW'($urandom), addr);
      k   = 0;
      cyc = 0;
      while (k < int'(BW) && cyc < 200) begin
         if (mode == 0)      dma_data_ready_i = 1'b1;
         else if (mode == 1) dma_data_ready_i = (cyc % 3 == 0);
         else                dma_data_ready_i = 1'($urandom);
         dma_data_v_i = 1'($urandom);
         #1;
         check("rd_data_v", 64'(dma_data_v_o), 64'(1));
         check("rd_data", dma_data_o, ref_mem[base + 32'(k)]);
         check("rd_data_yumi", 64'(dma_data_yumi_o), 64'(0));
         check("rd_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(0));
         tick();
         if (dma_data_ready_i) k++;
         cyc++;
      end
      check("rd_burst_len", 64'(k), 64'(BW));
   endtask

   task automatic fill_burst_random();
      for (int i = 0; i < int'(BW); i++) burst[i] = {$urandom, $urandom};
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      hold_v           = 1'b0;
      gaps             = 1'b0;
      reset_i          = 1'b1;
      dma_pkt_i        = '0;
      dma_pkt_v_i      = 1'b0;
      dma_data_ready_i = 1'b0;
      dma_data_i       = '0;
      dma_data_v_i     = 1'b0;
      for (int i = 0; i < int'(ELS); i++) ref_mem[i] = '0;

      repeat (3) tick();
      check("rst_data_v", 64'(dma_data_v_o), 64'(0));
      check("rst_data_yumi", 64'(dma_data_yumi_o), 64'(0));
      check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(0));
      reset_i = 1'b0;
      tick();

      // Full write then read back, no stalls
      for (int i = 0; i < int'(BW); i++) burst[i] = 64'(32'h11 + i);
      do_write(30'h40, 8'hFF);
      do_read(30'h40, 0);

      // Masked write over a previously written block
      for (int i = 0; i < int'(BW); i++) burst[i] = 64'(i);
      do_write(30'h80, 8'hFF);
      for (int i = 0; i < int'(BW); i++) burst[i] = 64'(32'hA0 + i);
      do_write(30'h80, 8'b1010_0101);
      do_read(30'h80, 0);

      // Ready stalls on a read
      do_read(30'h40, 1);

      // Address wrap-around and unaligned address
      fill_burst_random();
      do_write(30'h2040, 8'hFF);
      do_read(30'h40, 0);
      do_read(30'h47, 2);

      // Back-to-back packets with packet valid held high
      hold_v = 1'b1;
      fill_burst_random();
      do_write(30'h100, 8'hFF);
      do_read(30'h100, 0);
      fill_burst_random();
      do_write(30'h100, 8'h3C);
      do_read(30'h100, 0);
      hold_v      = 1'b0;
      dma_pkt_v_i = 1'b0;

      // Reset on the 4th word of a read abandons the burst and clears storage
      accept(1'b0, 8'hFF, 30'h40);
      for (int k = 0; k < 3; k++) begin
         dma_data_ready_i = 1'b1;
         #1;
         check("rst_rd_data", dma_data_o, ref_mem[base_of(30'h40) + 32'(k)]);
         tick();
      end
      dma_data_ready_i = 1'b1;
      #1;
      check("rst_rd_v_before", 64'(dma_data_v_o), 64'(1));
      reset_i = 1'b1;
      #1;
      check("rst_rd_v_drop", 64'(dma_data_v_o), 64'(0));
      check("rst_rd_yumi", 64'(dma_data_yumi_o), 64'(0));
      check("rst_pkt_yumi_mid", 64'(dma_pkt_yumi_o), 64'(0));
      for (int i = 0; i < int'(ELS); i++) ref_mem[i] = '0;
      tick();
      tick();
      reset_i = 1'b0;
      do_read(30'h40, 0);
      do_read(30'h80, 2);

      // Randomized mix of bursts, biased toward a few shared blocks
      gaps = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] addr;
         hold_v = 1'($urandom);
         if ($urandom_range(1) == 0) addr = AW'($urandom_range(0, 3) * 64 + $urandom_range(0, 63));
         else                        addr = AW'($urandom);
         if ($urandom_range(1) == 0) begin
            fill_burst_random();
            do_write(addr, BW'($urandom));
         end else begin
            do_read(addr, 2);
         end
      end
      hold_v      = 1'b0;
      dma_pkt_v_i = 1'b0;
      tick();
      check("final_data_v", 64'(dma_data_v_o), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_cache_dma_responder.md
BSG_CACHE_DMA_RESPONDER -- requirements
Module: bsg_cache_dma_responder

Interface
REQ-001 The module SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 The module SHALL have the following parameters, one per line (name, default, meaning):
- addr_width_p, 30, byte-address width of dma_pkt addr.
- data_width_p, 64, DMA word width in bits; a multiple of 8, with data_width_p/8 a power of two.
- block_size_in_words_p, 8, words per DMA burst; a power of two, at least 2.
- els_p, 1024, words of internal storage; a power of two and a multiple of block_size_in_words_p.
REQ-003 The module SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_i, in, 1, clock.
- reset_i, in, 1, asynchronous active-high reset.
- dma_pkt_i, in, bsg_cache_dma_pkt width (write_not_read, mask[block_size_in_words_p], addr[addr_width_p]), request packet.
- dma_pkt_v_i, in, 1, packet valid.
- dma_pkt_yumi_o, out, 1, packet consumed.
- dma_data_o, out, data_width_p, read data to the cache.
- dma_data_v_o, out, 1, read data valid.
- dma_data_ready_i, in, 1, cache can accept read data.
- dma_data_i, in, data_width_p, write data from the cache.
- dma_data_v_i, in, 1, write data valid.
- dma_data_yumi_o, out, 1, write data consumed.

Function
REQ-004 The module SHALL be a synthesizable flop-array memory that acts as the responder on the bsg_cache DMA interface.
REQ-005 The FSM SHALL have exactly three states: IDLE, READ and WRITE.
REQ-006 Packet acceptance:
- dma_pkt_yumi_o = dma_pkt_v_i & (state==IDLE), driven combinationally.
- On acceptance, the module latches the base word index, the mask and the direction.
- The next state is READ if write_not_read=0 and WRITE if write_not_read=1.
REQ-007 Base word index computation:
- base = (addr >> log2(data_width_p/8)) mod els_p.
- The low log2(block_size_in_words_p) bits of base are then forced to 0.
- Addresses beyond the storage wrap silently.
REQ-008 A word counter SHALL have width log2(block_size_in_words_p), reset on acceptance, increment per transferred word and wrap to 0 after the last word.
REQ-009 READ state:
- dma_data_v_o=1 and dma_data_o = mem[base+count], read combinationally.
- A word transfers when dma_data_v_o & dma_data_ready_i.
- When the word with count=block_size_in_words_p-1 transfers, the next state is IDLE.
REQ-010 READ data SHALL stay stable while dma_data_ready_i=0, and there is no timeout.
REQ-011 WRITE state:
- dma_data_yumi_o = dma_data_v_i, driven combinationally.
- On each yumi, mem[base+count] <= dma_data_i only if mask[count]=1; otherwise the storage is unchanged but the word is still consumed and counted.
- When the last word is consumed, the next state is IDLE.
REQ-012 Throughput SHALL be one word per cycle during a burst, with one mandatory IDLE cycle between bursts; a packet is never accepted while in READ or WRITE.
REQ-013 Outside the named states, outputs SHALL be: dma_data_v_o=0, dma_data_yumi_o=0, and dma_data_o=0 when not in READ.
REQ-014 dma_data_v_i SHALL be ignored outside WRITE, and dma_data_ready_i SHALL be ignored outside READ.
REQ-015 A read followed immediately by a write (or the reverse) to the same block SHALL observe fully-completed prior data, since bursts are serialized.

Reset
REQ-016 Asserting reset_i SHALL immediately (asynchronously) force: state=IDLE, counter=0, latched packet fields=0, all memory words=0, dma_pkt_yumi_o=0 when dma_pkt_v_i=0, dma_data_v_o=0 and dma_data_yumi_o=0.
REQ-017 Reset asserted mid-burst SHALL abandon the burst: no further words are driven or consumed, and no partial-write rollback is performed.
REQ-018 After reset deasserts, the first packet SHALL be accepted in the first cycle that dma_pkt_v_i=1.

Verification
REQ-019 Default parameters; write addr=0x40, mask=8'hFF, data words 0x11..0x18 with dma_data_v_i held high -> yumi on 8 consecutive cycles; then a read of addr=0x40 -> dma_data_o sequence 0x11..0x18 with ready held high, v_o for exactly 8 cycles.
REQ-020 Write addr=0x80, mask=8'b1010_0101, data 0xA0..0xA7 after a prior full write of 0x00..0x07 -> a read returns 0xA0,0x01,0xA2,0x03,0x04,0xA5,0x06,0xA7.
REQ-021 Read addr=0x40 with dma_data_ready_i toggling 1,0,0,1,... -> each word is held until ready, there are no skipped or duplicated words, and the burst ends after the 8th handshake.
REQ-022 Write addr=0x2000+0x40 (beyond 8 KB storage) -> a read at addr=0x40 returns the same data (wrap-around); addr=0x47 (unaligned) -> access to block base 0x40.
REQ-023 dma_pkt_v_i held high with back-to-back packets -> yumi only in IDLE, with exactly one IDLE cycle between bursts; reset asserted on the 4th word of a read -> dma_data_v_o drops in the same cycle, and a subsequent read returns all zeros.
